// File: rtl/ifd_prefetch.sv
// Instruction prefetch unit.
// Issues one-word reads ahead of the executor into a small circular queue,
// presents the head entry with pre-decoded opcode flags, flushes on a
// control-flow redirect and stops fetching once a HLT has been queued.
// reset_n is active-high despite its name: the block is in reset while it is 1.
module ifd_prefetch #(
  parameter int                    ADDR_WIDTH    = 12,
  parameter int                    DATA_WIDTH    = 12,
  parameter int                    QDEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o200
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           stall,
  input  logic                           redirect_valid,
  input  logic [ADDR_WIDTH-1:0]          redirect_addr,
  output logic                           mem_rd_req,
  output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]          mem_rd_data,
  output logic                           dec_valid,
  output logic [DATA_WIDTH-1:0]          dec_instr,
  output logic [ADDR_WIDTH-1:0]          dec_pc,
  output logic                           dec_is_mem,
  output logic                           dec_is_op7,
  output logic                           dec_is_hlt,
  output logic [$clog2(QDEPTH+1)-1:0]    q_count,
  output logic                           done
);

  localparam int                    CNT_W    = $clog2(QDEPTH + 1);
  localparam int                    PTR_W    = $clog2(QDEPTH);
  localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(QDEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] HLT_WORD = DATA_WIDTH'(12'o7402);

  typedef enum logic [1:0] {
    ST_RUN,        // issuing reads
    ST_HALT_PEND,  // HLT is queued, older entries still draining
    ST_DONE        // HLT consumed, block is idle until reset
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   fetch_pc;
  logic [ADDR_WIDTH-1:0]   resp_pc;    // address of the read whose data arrives this cycle
  logic                    inflight;   // a read was issued last cycle
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [DATA_WIDTH-1:0]   q_instr [QDEPTH];
  logic [ADDR_WIDTH-1:0]   q_pc    [QDEPTH];

  logic                    redirect_take;
  logic [CNT_W:0]          occupancy;
  logic                    push;
  logic                    pop;
  logic                    push_hlt;
  logic [2:0]              head_op;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Request generation, queue handshakes and head-entry decode.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    redirect_take = redirect_valid && (state != ST_DONE);
    // Entries already held plus the one response still on its way.
    occupancy     = {1'b0, q_count} + (CNT_W+1)'(inflight);
    mem_rd_req    = !reset_n && (state == ST_RUN) && !redirect_valid &&
                    (occupancy < (CNT_W+1)'(QDEPTH));
    mem_rd_addr   = reset_n ? '0 : fetch_pc;

    // Responses are accepted only while fetching; anything arriving after a
    // HLT was queued, or in a redirect cycle, is dropped.
    push          = inflight && (state == ST_RUN) && !redirect_valid;
    push_hlt      = push && (mem_rd_data == HLT_WORD);

    dec_valid     = !reset_n && (q_count != '0) && (state != ST_DONE);
    dec_instr     = dec_valid ? q_instr[rd_ptr] : '0;
    dec_pc        = dec_valid ? q_pc[rd_ptr]    : '0;
    head_op       = dec_instr[DATA_WIDTH-1 -: 3];
    dec_is_mem    = dec_valid && (head_op < 3'd6);
    dec_is_op7    = dec_valid && (head_op == 3'd7);
    dec_is_hlt    = dec_valid && (dec_instr == HLT_WORD);

    pop           = dec_valid && !stall && !redirect_valid;
  end

  // Fetch FSM, fetch address, queue pointers and occupancy.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state    <= ST_RUN;
      fetch_pc <= START_ADDRESS;
      resp_pc  <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_count  <= '0;
      done     <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      inflight <= mem_rd_req;
      if (mem_rd_req) begin
        resp_pc <= fetch_pc;
      end

      if (redirect_take) begin
        // Redirect wins over push and pop: drop everything and restart.
        fetch_pc <= redirect_addr;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        q_count  <= '0;
        state    <= ST_RUN;
      end else begin
        if (mem_rd_req) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
        end
        if (push) begin
          wr_ptr <= next_ptr(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
        case ({push, pop})
          2'b10:   q_count <= q_count + CNT_W'(1);
          2'b01:   q_count <= q_count - CNT_W'(1);
          default: q_count <= q_count;
        endcase

        if (pop && dec_is_hlt) begin
          state <= ST_DONE;
          done  <= 1'b1;
        end else if (push_hlt) begin
          state <= ST_HALT_PEND;
        end
      end
    end
  end

  // Queue storage: write the arriving word and its fetch address at the tail.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; q_count alone decides which entries are valid.
    if (push) begin
      q_instr[wr_ptr] <= mem_rd_data;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_ifd_prefetch.sv
// Self-checking bench for ifd_prefetch: a one-cycle-latency memory model
// feeds a scoreboard of expected {pc, instr}; every consumed head entry is
// compared in order. Hand sequences cover stall, redirect, wrap, HLT and
// mid-operation reset; a vector table covers the opcode decodes.
module tb_ifd_prefetch;

  localparam logic [11:0] START    = 12'o200;
  localparam logic [11:0] HLT      = 12'o7402;
  localparam logic [11:0] TBL_BASE = 12'o3000;
  localparam int          N_TBL    = 8;

  typedef struct {
    logic [11:0] instr;
    logic        is_mem;
    logic        is_op7;
    logic        is_hlt;
  } vec_t;

  typedef struct {
    logic [11:0] pc;
    logic [11:0] instr;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_addr = '0;
  logic [11:0] mem_rd_data = '0;
  logic        mem_rd_req;
  logic [11:0] mem_rd_addr;
  logic        dec_valid;
  logic [11:0] dec_instr;
  logic [11:0] dec_pc;
  logic        dec_is_mem;
  logic        dec_is_op7;
  logic        dec_is_hlt;
  logic [2:0]  q_count;
  logic        done;

  vec_t        tbl [N_TBL];
  sb_t         sb_q [$];
  logic [11:0] exp_req_addr = START;
  logic        hlt_en = 1'b0;
  logic        hlt_seen = 1'b0;
  logic [11:0] hlt_addr = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  ifd_prefetch dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .mem_rd_req     (mem_rd_req),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_is_mem     (dec_is_mem),
    .dec_is_op7     (dec_is_op7),
    .dec_is_hlt     (dec_is_hlt),
    .q_count        (q_count),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: HLT at a chosen address, the decode table, else 0o1000+addr.
  function automatic logic [11:0] mem_word(input logic [11:0] a);
    if (hlt_en && a == hlt_addr) return HLT;
    if (a >= TBL_BASE && a < TBL_BASE + 12'(N_TBL)) return tbl[int'(a - TBL_BASE)].instr;
    return 12'o1000 + a;
  endfunction

  // Decode flags as defined for the instruction set: {is_mem, is_op7, is_hlt}.
  function automatic logic [2:0] exp_flags(input logic [11:0] w);
    return {w[11:9] < 3'd6, w[11:9] == 3'd7, w == HLT};
  endfunction

  // Memory model: answer each request one cycle later and record the expected entry.
  always @(posedge clk) begin
    logic        req;
    logic [11:0] a;
    logic [11:0] w;
    req = mem_rd_req;
    a   = mem_rd_addr;
    #1;
    if (req && !reset_n) begin
      check("req_addr", 32'(a), 32'(exp_req_addr));
      exp_req_addr = exp_req_addr + 12'd1;
      w = mem_word(a);
      mem_rd_data = w;
      if (!hlt_seen) begin
        sb_q.push_back('{pc: a, instr: w});
        if (w == HLT) hlt_seen = 1'b1;
      end
    end else begin
      mem_rd_data = '0;
    end
  end

  // Consumer monitor: compare every popped head entry against the scoreboard.
  always @(negedge clk) begin
    sb_t e;
    if (!reset_n) begin
      check("q_bound", 32'(q_count <= 3'd4), 32'd1);
      if (!dec_valid) begin
        check("flags_idle", 32'({dec_is_mem, dec_is_op7, dec_is_hlt}), 32'd0);
      end else if (!stall && !redirect_valid) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_pop: DUT popped pc 'h%0h, expected no entry (t=%0t)", dec_pc, $time);
        end else begin
          e = sb_q.pop_front();
          check("pop_pc", 32'(dec_pc), 32'(e.pc));
          check("pop_instr", 32'(dec_instr), 32'(e.instr));
          check("pop_flags", 32'({dec_is_mem, dec_is_op7, dec_is_hlt}), 32'(exp_flags(e.instr)));
        end
      end
    end
  end

  task automatic do_reset(input logic en, input logic [11:0] ha);
    @(posedge clk); #2;
    reset_n = 1'b1;
    sb_q.delete();
    hlt_seen = 1'b0;
    exp_req_addr = START;
    hlt_en = en;
    hlt_addr = ha;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
  endtask

  task automatic do_redirect(input logic [11:0] a);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_addr  = a;
    @(posedge clk);
    sb_q.delete();
    exp_req_addr = a;
    #1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
  endtask

  task automatic wait_dec(input string name, input int budget);
    int k;
    k = 0;
    @(negedge clk);
    while (!dec_valid && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(dec_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   32'(mem_rd_req),  32'd0);
    check({tag, "_addr"},  32'(mem_rd_addr), 32'd0);
    check({tag, "_valid"}, 32'(dec_valid),   32'd0);
    check({tag, "_instr"}, 32'(dec_instr),   32'd0);
    check({tag, "_pc"},    32'(dec_pc),      32'd0);
    check({tag, "_flags"}, 32'({dec_is_mem, dec_is_op7, dec_is_hlt}), 32'd0);
    check({tag, "_count"}, 32'(q_count),     32'd0);
    check({tag, "_done"},  32'(done),        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    tbl[0] = '{12'o0000, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{12'o5777, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{12'o6000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{12'o6777, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{12'o7000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{12'o7401, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{12'o7403, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{12'o2402, 1'b1, 1'b0, 1'b0};

    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("rst");

    // Release reset: sequential fetch from START, first entry two cycles later.
    @(posedge clk); #1 reset_n = 1'b0;
    @(negedge clk);
    check("t1_req0", 32'(mem_rd_req), 32'd1);
    check("t1_addr0", 32'(mem_rd_addr), 32'o200);
    @(negedge clk);
    check("t1_addr1", 32'(mem_rd_addr), 32'o201);
    check("t1_valid1", 32'(dec_valid), 32'd0);
    @(negedge clk);
    check("t1_valid2", 32'(dec_valid), 32'd1);
    check("t1_pc2", 32'(dec_pc), 32'o200);
    check("t1_mem2", 32'(dec_is_mem), 32'd1);
    repeat (8) begin
      @(negedge clk);
      check("t1_stream", 32'(dec_valid), 32'd1);
    end

    // Stall for 10 cycles: queue saturates, no requests while full.
    @(posedge clk); #1 stall = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (q_count == 3'd4) check("t2_full_noreq", 32'(mem_rd_req), 32'd0);
    end
    check("t2_count", 32'(q_count), 32'd4);
    check("t2_req", 32'(mem_rd_req), 32'd0);
    @(posedge clk); #1 stall = 1'b0;
    repeat (8) @(negedge clk);

    // Redirect with three entries queued and a read in flight.
    @(posedge clk); #1 stall = 1'b1;
    do_redirect(12'o300);
    k = 0;
    @(negedge clk);
    while (!(q_count == 3'd2 && mem_rd_req) && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("t3_setup", 32'(q_count), 32'd2);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_addr  = 12'o400;
    @(negedge clk);
    check("t3_pre_count", 32'(q_count), 32'd3);
    check("t3_pre_req", 32'(mem_rd_req), 32'd0);
    @(posedge clk);
    sb_q.delete();
    exp_req_addr = 12'o400;
    #1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    @(negedge clk);
    check("t3_flush_count", 32'(q_count), 32'd0);
    check("t3_flush_valid", 32'(dec_valid), 32'd0);
    check("t3_new_req", 32'(mem_rd_req), 32'd1);
    check("t3_new_addr", 32'(mem_rd_addr), 32'o400);
    repeat (2) @(negedge clk);
    check("t3_head_valid", 32'(dec_valid), 32'd1);
    check("t3_head_pc", 32'(dec_pc), 32'o400);
    check("t3_head_instr", 32'(dec_instr), 32'o1400);
    @(posedge clk); #1 stall = 1'b0;
    repeat (8) @(negedge clk);

    // Opcode decode table: redirect to each vector and inspect the head.
    @(posedge clk); #1 stall = 1'b1;
    for (int i = 0; i < N_TBL; i++) begin
      do_redirect(TBL_BASE + 12'(i));
      wait_dec($sformatf("tbl%0d_wait", i), 6);
      check($sformatf("tbl%0d_pc", i),    32'(dec_pc),     32'(TBL_BASE + 12'(i)));
      check($sformatf("tbl%0d_instr", i), 32'(dec_instr),  32'(tbl[i].instr));
      check($sformatf("tbl%0d_mem", i),   32'(dec_is_mem), 32'(tbl[i].is_mem));
      check($sformatf("tbl%0d_op7", i),   32'(dec_is_op7), 32'(tbl[i].is_op7));
      check($sformatf("tbl%0d_hlt", i),   32'(dec_is_hlt), 32'(tbl[i].is_hlt));
    end

    // Fetch address wraps from all-ones to zero.
    @(posedge clk); #1 stall = 1'b0;
    do_redirect(12'o7776);
    k = 0;
    @(negedge clk);
    while (!(mem_rd_req && mem_rd_addr == 12'o7777) && k < 6) begin
      @(negedge clk);
      k++;
    end
    check("t4_at_top", 32'(mem_rd_addr), 32'o7777);
    @(negedge clk);
    check("t4_wrap_req", 32'(mem_rd_req), 32'd1);
    check("t4_wrap_addr", 32'(mem_rd_addr), 32'o0000);
    repeat (6) @(negedge clk);

    // HLT at 0o203: fetching stops, older entries drain, done after HLT pops.
    stall = 1'b1;
    do_reset(1'b1, 12'o203);
    k = 0;
    @(negedge clk);
    while (q_count != 3'd4 && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("t5_fill", 32'(q_count), 32'd4);
    repeat (3) begin
      @(negedge clk);
      check("t5_pend_req", 32'(mem_rd_req), 32'd0);
      check("t5_pend_done", 32'(done), 32'd0);
    end
    check("t5_head_pc", 32'(dec_pc), 32'o200);
    @(posedge clk); #1 stall = 1'b0;
    k = 0;
    @(negedge clk);
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("t5_done", 32'(done), 32'd1);
    check("t5_done_req", 32'(mem_rd_req), 32'd0);
    check("t5_done_valid", 32'(dec_valid), 32'd0);
    check("t5_done_count", 32'(q_count), 32'd0);
    check("t5_drained", 32'(sb_q.size()), 32'd0);
    do_redirect(12'o500);
    repeat (3) begin
      @(negedge clk);
      check("t5_ign_req", 32'(mem_rd_req), 32'd0);
      check("t5_ign_done", 32'(done), 32'd1);
      check("t5_ign_valid", 32'(dec_valid), 32'd0);
    end

    // Reset mid-operation with two entries queued and a read in flight.
    stall = 1'b1;
    do_reset(1'b0, 12'o0);
    k = 0;
    @(negedge clk);
    while (q_count != 3'd2 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("t6_setup", 32'(q_count), 32'd2);
    #1;
    reset_n = 1'b1;
    sb_q.delete();
    hlt_seen = 1'b0;
    exp_req_addr = START;
    #1;
    check_all_zero("t6_async");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    stall   = 1'b0;
    @(negedge clk);
    check("t6_first_req", 32'(mem_rd_req), 32'd1);
    check("t6_first_addr", 32'(mem_rd_addr), 32'o200);
    repeat (12) @(negedge clk);
    check("t6_stream", 32'(dec_valid), 32'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
